seq_chunk_adder: RTL and testbench
==================================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands a, b, cin valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  augend.
REQ-008 b  input  WIDTH  addend.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  sum/cout valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
REQ-013 cout  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 WIDTH SHALL be a nonzero multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-015 FSM SHALL have states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b, cin, clear chunk counter, go RUN.
REQ-017 RUN: in_ready=0; each cycle add chunk cnt (bits cnt*CHUNK+CHUNK-1..cnt*CHUNK) with stored carry, store chunk result and new carry, increment cnt.
REQ-018 RUN SHALL go DONE on the edge processing chunk NCHUNK-1; chunk 0 is least significant.
REQ-019 Latency: accept on edge k -> out_valid=1 visible after edge k+NCHUNK.
REQ-020 DONE: out_valid=1, in_ready=0; sum and cout held stable until out_valid&&out_ready, then go IDLE.
REQ-021 No operand acceptance in RUN or DONE; in_valid there is ignored and inputs are not sampled.
REQ-022 Minimum initiation interval SHALL be NCHUNK+2 cycles (accept, NCHUNK RUN edges, handshake).
REQ-023 CHUNK==WIDTH SHALL be legal: one RUN cycle.
REQ-024 Operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-025 sum, cout, out_valid SHALL be registered; in_ready SHALL decode from state only.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, cnt=0, sum=0, cout=0, out_valid=0, and drop any in-flight operation; in_ready=1 from the first cycle after reset.
REQ-027 Reset in RUN or DONE SHALL discard the result without out_valid assertion.

Configuration
REQ-028 Macro SEQ_ADDER_OVF_EN defined: extra output ovf (1 bit), registered with sum, signed two's-complement overflow = carry into MSB XOR cout, reset 0, held in DONE.
REQ-029 Macro undefined: no ovf port, no overflow logic; all other behaviour identical.

Structure
REQ-030 Package seq_adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants.
REQ-031 Sub-module rca_chunk SHALL implement a CHUNK-wide combinational ripple-carry adder (a, b, cin -> sum, cout, msb carry-in), instantiated once.

Verification (WIDTH=16, CHUNK=4)
REQ-032 a=0x0003 b=0x0004 cin=0 -> sum=0x0007 cout=0, out_valid after 4 edges post-accept.
REQ-033 a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 (carry through all chunks); with SEQ_ADDER_OVF_EN ovf=0.
REQ-034 a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0; with SEQ_ADDER_OVF_EN ovf=1.
REQ-035 a=0x000B b=0x0003 cin=1 with out_ready=0 for 5 cycles -> sum=0x000F held, in_ready=0, new in_valid ignored; IDLE after out_ready=1.
REQ-036 rst=1 two cycles after accept -> out_valid stays 0, sum=0, in_ready=1 next cycle; next op 0x0005+0x0007 -> 0x000C.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and default sizing for the sequential chunked adder.
// Holds the controller state encoding and the default operand/chunk widths.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; zero latency, no flow control.
// Also exports the carry into its top bit so the caller can derive signed overflow.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    always_comb begin
        logic carry;
        carry   = cin;
        sum     = '0;
        msb_cin = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                msb_cin = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder: WIDTH-bit sum computed CHUNK bits per cycle, result after WIDTH/CHUNK RUN edges.
// Valid/ready on both sides; a finished result is held until out_ready. SEQ_ADDER_OVF_EN adds ovf.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic            carry_q, cout_q, out_valid_q;
    logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
    logic            ch_cout, ch_msb_cin;
    logic            last;

    assign last = (cnt == CW'(NCHUNK - 1));
    assign ch_a = a_q[int'(cnt)*CHUNK +: CHUNK];
    assign ch_b = b_q[int'(cnt)*CHUNK +: CHUNK];

    rca_chunk #(.CHUNK(CHUNK)) u_rca (
        .a       (ch_a),
        .b       (ch_b),
        .cin     (carry_q),
        .sum     (ch_sum),
        .cout    (ch_cout),
        .msb_cin (ch_msb_cin)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Operands are sampled only in IDLE, so later input changes cannot disturb a running add.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(cnt)*CHUNK +: CHUNK] <= ch_sum;
                    carry_q <= ch_cout;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        cout_q      <= ch_cout;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst)                     ovf_q <= 1'b0;
        else if (state == RUN && last) ovf_q <= ch_msb_cin ^ ch_cout;
    end
    assign ovf = ovf_q;
`else
    logic unused_msb_cin;
    assign unused_msb_cin = ch_msb_cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at WIDTH=16, CHUNK=4: vector table plus stall and reset sequences.
module tb_seq_chunk_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and drain it; returns with the DUT back in IDLE.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vcin,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vcin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = ~va; b = ~vb; cin = ~vcin;
        check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(NCHUNK));
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SEQ_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected x in ovf column");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum,
                   vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Stalled consumer: result held, new requests ignored, inputs perturbed mid-flight.
        begin
            int n;
            a = 16'h000B; b = 16'h0003; cin = 1'b1; in_valid = 1'b1;
            tick();
            a = 16'h1111; b = 16'h2222; cin = 1'b0;
            n = 0;
            while (n < 20) begin
                tick();
                n++;
                if (out_valid) break;
            end
            check("stall_latency", 32'(n), 32'(NCHUNK));
            for (int k = 0; k < 5; k++) begin
                check($sformatf("stall_valid_%0d", k), 32'(out_valid), 32'd1);
                check($sformatf("stall_sum_%0d", k), 32'(sum), 32'h000F);
                check($sformatf("stall_ready_%0d", k), 32'(in_ready), 32'd0);
                tick();
            end
            check("stall_cout", 32'(cout), 32'd0);
            out_ready = 1'b1;
            in_valid  = 1'b0;
            tick();
            out_ready = 1'b0;
            check("stall_idle_ready", 32'(in_ready), 32'd1);
            check("stall_idle_valid", 32'(out_valid), 32'd0);
        end

        // Reset two edges after acceptance discards the operation.
        a = 16'h00F0; b = 16'h000F; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (out_valid) seen++;
            end
            check("mid_rst_no_valid", 32'(seen), 32'd0);
        end
        run_op(16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
